// File: rtl/tetrix_pkg.sv
// Shared definitions for the Tetrix display path.
// Provides playfield geometry, the row-scan state encoding and the
// shift-word width used by matrix_scan and frame_buffer.
package tetrix_pkg;

   localparam int ROWS    = 16;
   localparam int COLS    = 8;
   localparam int ROW_W   = 4;
   localparam int SHIFT_W = ROWS + COLS;
   localparam int BIT_W   = $clog2(SHIFT_W);

   typedef enum logic [1:0] {
      S_LOAD,
      S_SHIFT,
      S_LATCH,
      S_HOLD
   } scan_state_t;

   // One-hot row select for the 16 row driver outputs of the shift chain.
   function automatic logic [ROWS-1:0] row_onehot(input logic [ROW_W-1:0] row);
      row_onehot      = '0;
      row_onehot[row] = 1'b1;
   endfunction

endpackage

// File: rtl/frame_buffer.sv
// Double-buffered 16x8 playfield bitmap.
// Ports:
//   clk_in, rst_n  - system clock, synchronous active-low reset
//   wr_en/wr_row/wr_data - write port, always into the back bank
//   toggle         - exchange front and back banks at the next edge
//   rd_row/rd_data - combinational read port of the front bank
module frame_buffer
   import tetrix_pkg::*;
(
   input  logic             clk_in,
   input  logic             rst_n,
   input  logic             wr_en,
   input  logic [ROW_W-1:0] wr_row,
   input  logic [COLS-1:0]  wr_data,
   input  logic             toggle,
   input  logic [ROW_W-1:0] rd_row,
   output logic [COLS-1:0]  rd_data
);

   logic [COLS-1:0] r_bank0 [ROWS];
   logic [COLS-1:0] r_bank1 [ROWS];
   logic            r_front;

   // A write coinciding with a toggle lands in the pre-toggle back bank,
   // which becomes the displayed bank from the next frame on.
   always_ff @(posedge clk_in) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < ROWS; i++) begin
            r_bank0[i] <= '0;
            r_bank1[i] <= '0;
         end
         r_front <= 1'b0;
      end else begin
         if (wr_en) begin
            if (r_front) r_bank0[wr_row] <= wr_data;
            else         r_bank1[wr_row] <= wr_data;
         end
         if (toggle) r_front <= ~r_front;
      end
   end

   always_comb begin
      rd_data = r_front ? r_bank1[rd_row] : r_bank0[rd_row];
   end

endmodule

// File: rtl/matrix_scan.sv
// Row-scan driver for the LED matrix header.
// Serialises {row_onehot, columns} into three cascaded 74HC595-style
// shift registers one row at a time, then latches and holds the row.
// Ports:
//   clk_in, rst_n       - system clock, synchronous active-low reset
//   wr_en/wr_row/wr_data - back-buffer write port
//   swap / swap_done    - buffer exchange request / applied pulse
//   frame_done          - pulse after row 15's hold
//   sdata, sclk, latch, oe_n - shift chain controls (all registered)
//   scan_row            - row being loaded or displayed
module matrix_scan
   import tetrix_pkg::*;
#(
   parameter int CLK_DIV  = 4,
   parameter int ROW_HOLD = 2000
) (
   input  logic             clk_in,
   input  logic             rst_n,
   input  logic             wr_en,
   input  logic [ROW_W-1:0] wr_row,
   input  logic [COLS-1:0]  wr_data,
   input  logic             swap,
   output logic             swap_done,
   output logic             frame_done,
   output logic             sdata,
   output logic             sclk,
   output logic             latch,
   output logic             oe_n,
   output logic [ROW_W-1:0] scan_row
);

   localparam int CNT_MAX = (CLK_DIV > ROW_HOLD) ? CLK_DIV : ROW_HOLD;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(CLK_DIV - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(ROW_HOLD - 1);
   localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(ROWS - 1);

   scan_state_t        r_state, w_state;
   logic [CNT_W-1:0]   r_cnt, w_cnt;
   logic [BIT_W-1:0]   r_bit, w_bit;
   logic               r_high, w_high;
   logic [ROW_W-1:0]   r_row, w_row;
   logic [SHIFT_W-1:0] r_shift, w_shift;
   logic               r_pend, w_pend;
   logic               r_sdata, w_sdata;
   logic               r_sclk, w_sclk;
   logic               r_latch, w_latch;
   logic               r_oe_n, w_oe_n;
   logic               r_frame_done, w_frame_done;
   logic               r_swap_done, w_swap_done;
   logic               w_toggle;
   logic [COLS-1:0]    w_rd_data;
   logic [SHIFT_W-1:0] w_word;

   frame_buffer u_frame_buffer (
      .clk_in  (clk_in),
      .rst_n   (rst_n),
      .wr_en   (wr_en),
      .wr_row  (wr_row),
      .wr_data (wr_data),
      .toggle  (w_toggle),
      .rd_row  (r_row),
      .rd_data (w_rd_data)
   );

   always_comb begin
      w_state      = r_state;
      w_cnt        = r_cnt;
      w_bit        = r_bit;
      w_high       = r_high;
      w_row        = r_row;
      w_shift      = r_shift;
      w_pend       = r_pend | swap;
      w_sdata      = r_sdata;
      w_sclk       = r_sclk;
      w_latch      = r_latch;
      w_oe_n       = r_oe_n;
      w_frame_done = 1'b0;
      w_swap_done  = 1'b0;
      w_toggle     = 1'b0;
      w_word       = {row_onehot(r_row), w_rd_data};

      case (r_state)
         S_LOAD: begin
            w_shift = w_word;
            w_bit   = BIT_W'(SHIFT_W - 1);
            w_high  = 1'b0;
            w_cnt   = '0;
            w_sdata = w_word[SHIFT_W-1];
            w_sclk  = 1'b0;
            w_state = S_SHIFT;
         end
         S_SHIFT: begin
            if (r_cnt == DIV_LAST) begin
               w_cnt = '0;
               if (!r_high) begin
                  w_high = 1'b1;
                  w_sclk = 1'b1;
               end else if (r_bit == '0) begin
                  w_sclk  = 1'b0;
                  w_latch = 1'b1;
                  w_state = S_LATCH;
               end else begin
                  // next bit is presented on the same edge sclk falls
                  w_high  = 1'b0;
                  w_sclk  = 1'b0;
                  w_bit   = r_bit - 1'b1;
                  w_sdata = r_shift[w_bit];
               end
            end else begin
               w_cnt = r_cnt + 1'b1;
            end
         end
         S_LATCH: begin
            if (r_cnt == DIV_LAST) begin
               w_cnt   = '0;
               w_latch = 1'b0;
               w_oe_n  = 1'b0;
               w_state = S_HOLD;
            end else begin
               w_cnt = r_cnt + 1'b1;
            end
         end
         S_HOLD: begin
            if (r_cnt == HOLD_LAST) begin
               w_cnt   = '0;
               w_state = S_LOAD;
               if (r_row == ROW_LAST) begin
                  w_row        = '0;
                  w_frame_done = 1'b1;
                  // w_pend already folds in a swap arriving this cycle
                  if (w_pend) begin
                     w_toggle    = 1'b1;
                     w_pend      = 1'b0;
                     w_swap_done = 1'b1;
                  end
               end else begin
                  w_row = r_row + 1'b1;
               end
            end else begin
               w_cnt = r_cnt + 1'b1;
            end
         end
         default: w_state = S_LOAD;
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (!rst_n) begin
         r_state      <= S_LOAD;
         r_cnt        <= '0;
         r_bit        <= '0;
         r_high       <= 1'b0;
         r_row        <= '0;
         r_shift      <= '0;
         r_pend       <= 1'b0;
         r_sdata      <= 1'b0;
         r_sclk       <= 1'b0;
         r_latch      <= 1'b0;
         r_oe_n       <= 1'b1;
         r_frame_done <= 1'b0;
         r_swap_done  <= 1'b0;
      end else begin
         r_state      <= w_state;
         r_cnt        <= w_cnt;
         r_bit        <= w_bit;
         r_high       <= w_high;
         r_row        <= w_row;
         r_shift      <= w_shift;
         r_pend       <= w_pend;
         r_sdata      <= w_sdata;
         r_sclk       <= w_sclk;
         r_latch      <= w_latch;
         r_oe_n       <= w_oe_n;
         r_frame_done <= w_frame_done;
         r_swap_done  <= w_swap_done;
      end
   end

   assign swap_done  = r_swap_done;
   assign frame_done = r_frame_done;
   assign sdata      = r_sdata;
   assign sclk       = r_sclk;
   assign latch      = r_latch;
   assign oe_n       = r_oe_n;
   assign scan_row   = r_row;

endmodule

// File: tb/tb_matrix_scan.sv
// Directed bench for matrix_scan with CLK_DIV = 1, ROW_HOLD = 4
// (row period 54 cycles, frame 864 cycles). A negedge monitor rebuilds
// each shifted word from sdata on sclk rising edges and files it by
// scan_row when latch rises; it also watches the shift-chain timing rules.
module tb_matrix_scan;

   logic       clk_in = 1'b0;
   logic       rst_n;
   logic       wr_en;
   logic [3:0] wr_row;
   logic [7:0] wr_data;
   logic       swap;
   logic       swap_done, frame_done, sdata, sclk, latch, oe_n;
   logic [3:0] scan_row;

   int n_total = 0;
   int n_fail  = 0;
   int cyc     = 0;
   int sd_cnt  = 0;

   logic [23:0] acc;
   logic [23:0] words [16];
   logic        p_sclk, p_latch, p_sdata;

   matrix_scan #(.CLK_DIV(1), .ROW_HOLD(4)) dut (
      .clk_in     (clk_in),
      .rst_n      (rst_n),
      .wr_en      (wr_en),
      .wr_row     (wr_row),
      .wr_data    (wr_data),
      .swap       (swap),
      .swap_done  (swap_done),
      .frame_done (frame_done),
      .sdata      (sdata),
      .sclk       (sclk),
      .latch      (latch),
      .oe_n       (oe_n),
      .scan_row   (scan_row)
   );

   always #5 clk_in = ~clk_in;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_in);
      #1;
      cyc++;
   endtask

   task automatic goto(input int target);
      while (cyc < target) tick();
   endtask

   always @(negedge clk_in) begin
      if (!rst_n) begin
         acc     = '0;
         p_sclk  = 1'b0;
         p_latch = 1'b0;
         p_sdata = 1'b0;
      end else begin
         if (p_sclk && sclk) check("sdata_stable_sclk_high", {31'd0, sdata}, {31'd0, p_sdata});
         if (latch) check("latch_with_sclk", {31'd0, sclk}, 32'd0);
         if (swap_done) begin
            sd_cnt++;
            check("swap_done_with_frame_done", {31'd0, frame_done}, 32'd1);
         end
         if (!p_sclk && sclk) acc = {acc[22:0], sdata};
         if (latch && !p_latch) words[scan_row] = acc;
         p_sclk  = sclk;
         p_latch = latch;
         p_sdata = sdata;
      end
   end

   initial begin
      rst_n = 1'b0; wr_en = 1'b0; wr_row = '0; wr_data = '0; swap = 1'b0;
      tick(); tick(); tick();
      check("reset_outputs", {26'd0, sdata, sclk, latch, oe_n, frame_done, swap_done}, 32'b000100);
      check("reset_scan_row", {28'd0, scan_row}, 32'd0);

      // reset release: C0 is the first LOAD
      rst_n = 1'b1;
      cyc   = 0;
      goto(1);   check("bit23_sdata", {31'd0, sdata}, 32'd0);
                 check("bit23_sclk_low", {31'd0, sclk}, 32'd0);
      goto(31);  check("bit8_sdata_row_sel", {31'd0, sdata}, 32'd1);
      goto(48);  check("bit0_sclk_high", {31'd0, sclk}, 32'd1);
                 check("pre_latch", {30'd0, latch, oe_n}, 32'b01);
      goto(49);  check("latch_cycle", {29'd0, latch, sclk, oe_n}, 32'b101);
      goto(50);  check("post_latch", {30'd0, latch, oe_n}, 32'b00);
                 check("first_word", {8'd0, words[0]}, 32'h000100);
      goto(53);  check("row0_last_hold", {28'd0, scan_row}, 32'd0);
      goto(54);  check("row_period_54", {28'd0, scan_row}, 32'd1);

      // write + swap
      goto(60);
      wr_en = 1'b1; wr_row = 4'd3; wr_data = 8'hA5;
      tick();
      wr_en = 1'b0; swap = 1'b1;
      tick();
      swap = 1'b0;
      goto(100); swap = 1'b1; tick(); swap = 1'b0;
      goto(212);  check("frame0_row3_back_hidden", {8'd0, words[3]}, 32'h000800);
      goto(863);  check("pre_boundary_frame_done", {31'd0, frame_done}, 32'd0);
                  check("pre_boundary_row", {28'd0, scan_row}, 32'd15);
      goto(864);  check("boundary1_pulses", {30'd0, frame_done, swap_done}, 32'b11);
                  check("boundary1_row_wrap", {28'd0, scan_row}, 32'd0);
      goto(865);  check("frame_done_one_cycle", {30'd0, frame_done, swap_done}, 32'b00);
      goto(914);  check("frame1_row0", {8'd0, words[0]}, 32'h000100);
      goto(1076); check("frame1_row3_swapped", {8'd0, words[3]}, 32'h0008A5);

      // tear-free: write without swap
      goto(1100);
      wr_en = 1'b1; wr_row = 4'd0; wr_data = 8'hFF;
      tick();
      wr_en = 1'b0;
      goto(1728); check("boundary2_no_swap", {30'd0, frame_done, swap_done}, 32'b10);
      goto(1778); check("frame2_row0_unchanged", {8'd0, words[0]}, 32'h000100);
                  check("swap_done_count_1", sd_cnt, 32'd1);

      // swap and write in the boundary cycle
      goto(2591);
      swap = 1'b1; wr_en = 1'b1; wr_row = 4'd5; wr_data = 8'h3C;
      tick();
      swap = 1'b0; wr_en = 1'b0;
      check("boundary3_collision_pulses", {30'd0, frame_done, swap_done}, 32'b11);
      goto(2642); check("frame3_row0_ff", {8'd0, words[0]}, 32'h0001FF);
      goto(2804); check("frame3_row3_old_bank", {8'd0, words[3]}, 32'h000800);
      goto(2912); check("frame3_row5_collision_write", {8'd0, words[5]}, 32'h00203C);

      // pending swap then reset at bit 10 of row 7
      goto(2950); swap = 1'b1; tick(); swap = 1'b0;
      goto(2997); check("row7_bit10_low_phase", {28'd0, scan_row}, 32'd7);
      rst_n = 1'b0;
      tick();
      check("midshift_reset_outputs", {26'd0, sdata, sclk, latch, oe_n, frame_done, swap_done}, 32'b000100);
      check("midshift_reset_row", {28'd0, scan_row}, 32'd0);
      rst_n = 1'b1;
      cyc   = 0;
      goto(50);  check("post_reset_row0", {8'd0, words[0]}, 32'h000100);
      goto(212); check("post_reset_row3", {8'd0, words[3]}, 32'h000800);
      goto(320); check("post_reset_row5", {8'd0, words[5]}, 32'h002000);
      goto(864); check("post_reset_swap_discarded", {30'd0, frame_done, swap_done}, 32'b10);
      goto(865); check("swap_done_count_2", sd_cnt, 32'd2);

      $display("%0d/%0d checks passed", n_total - n_fail, n_total);
      $finish;
   end

endmodule
